// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the operand-streaming accumulator around CLA_64bit.
//   WIDTH   : datapath width, fixed by the CLA instance
//   MAX_OPS : largest operand count per accumulation run
//   CNT_W   : width of num_ops and of the internal beat counter
//   state_t : accumulator FSM states
// ---------------------------------------------------------------------------
package cla_pkg;

   localparam int WIDTH   = 64;
   localparam int MAX_OPS = 16;
   localparam int CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/CLA_64bit.sv
// ---------------------------------------------------------------------------
// CLA_64bit
// Combinational 64-bit carry-lookahead adder built from 4-bit lookahead
// groups; each group's generate/propagate pair produces the carry into the
// next group.
// Ports:
//   a, b : addends (64 bits)
//   cin  : carry into bit 0
//   sum  : a + b + cin, modulo 2^64
// ---------------------------------------------------------------------------
module CLA_64bit
   import cla_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);

   localparam int NGRP = WIDTH / 4;

   // c[k] is the carry into group k.
   logic [NGRP-1:0] c;

   assign c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < NGRP; gi++) begin : g_grp
         logic [2:0] gg;
         logic [3:0] pp;
         logic [3:0] cc;

         assign gg = a[4*gi +: 3] & b[4*gi +: 3];
         assign pp = a[4*gi +: 4] ^ b[4*gi +: 4];

         // Intra-group lookahead: every carry is a flat function of the
         // group's carry-in, with no ripple between bits.
         assign cc[0] = c[gi];
         assign cc[1] = gg[0] | (pp[0] & c[gi]);
         assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[gi]);
         assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & c[gi]);

         assign sum[4*gi +: 4] = pp ^ cc;

         // The top group has no successor; its carry-out is not needed
         // because overflow is detected by the caller from sum and a.
         if (gi < NGRP - 1) begin : g_next
            logic grp_g;
            logic grp_p;

            assign grp_g = (a[4*gi+3] & b[4*gi+3])
                         | (pp[3] & gg[2])
                         | (pp[3] & pp[2] & gg[1])
                         | (pp[3] & pp[2] & pp[1] & gg[0]);
            assign grp_p = &pp;
            assign c[gi+1] = grp_g | (grp_p & c[gi]);
         end
      end
   endgenerate

endmodule

// File: rtl/cla_accum.sv
// ---------------------------------------------------------------------------
// cla_accum
// Streams a programmed number of 64-bit operands through CLA_64bit and
// returns their sum plus a sticky unsigned-carry flag.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, num_ops, cin   : run request; count and carry-in latched in IDLE
//   in_valid/in_ready     : operand handshake, in_data is the operand
//   out_valid/out_ready   : result handshake
//   out_sum, out_carry    : accumulated sum (mod 2^64), any-add-overflowed
//   busy                  : high while accumulating or holding a result
// ---------------------------------------------------------------------------
module cla_accum
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_ops,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             busy
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] n_reg;
   logic             cin_reg;
   logic             flag_reg;

   logic [WIDTH-1:0] sum;
   logic [CNT_W-1:0] n_clamped;
   logic             cin_eff;
   logic             beat;
   logic             last_beat;
   logic             carry_out;

   assign n_clamped = (num_ops > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : num_ops;

   // The latched carry-in only feeds the very first add of a run.
   assign cin_eff   = cin_reg & (count_reg == '0);
   assign beat      = (state_reg == ACCUM) & in_valid;
   assign last_beat = beat & ((count_reg + CNT_W'(1)) == n_reg);

   // Unsigned overflow: the wrapped sum falls below acc, or equals it only
   // because a carry-in pushed a full 2^64 wrap (b = all ones).
   assign carry_out = (sum < acc_reg) | (cin_eff & (sum == acc_reg));

   CLA_64bit u_cla (
      .a   (acc_reg),
      .b   (in_data),
      .cin (cin_eff),
      .sum (sum)
   );

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      out_sum    = '0;
      out_carry  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (n_clamped == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_sum   = acc_reg;
            out_carry = flag_reg;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         count_reg <= '0;
         n_reg     <= '0;
         cin_reg   <= 1'b0;
         flag_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && start) begin
            n_reg     <= n_clamped;
            cin_reg   <= cin;
            acc_reg   <= '0;
            count_reg <= '0;
            flag_reg  <= 1'b0;
         end
         if (beat) begin
            acc_reg   <= sum;
            flag_reg  <= flag_reg | carry_out;
            count_reg <= count_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cla_accum.sv
// ---------------------------------------------------------------------------
// tb_cla_accum
// Directed scenarios with literal expectations, then randomized traffic.
// A reference model tracks the run phase and computes each result from the
// list of accepted operands using wide arithmetic; a compare process checks
// every DUT output against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_cla_accum;
   import cla_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] num_ops;
   logic             cin;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             busy;

   cla_accum dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_ops   (num_ops),
      .cin       (cin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // phase: 0 waiting for start, 1 collecting operands, 2 holding result
   int               m_phase = 0;
   int               m_n     = 0;
   logic             m_cin   = 1'b0;
   logic [63:0]      m_q[$];
   logic [63:0]      m_sum   = '0;
   logic             m_carry = 1'b0;
   int               txn     = 0;

   // Sum of the operand list with carry-in on the first add; the carry flag
   // is set when any single add exceeds 64 bits.
   function automatic void ref_sum(input logic [63:0] q[$], input logic c,
                                   output logic [63:0] s, output logic co);
      logic [64:0] t;
      s  = '0;
      co = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         t  = {1'b0, s} + {1'b0, q[i]} + 65'((i == 0) ? c : 1'b0);
         co = co | t[64];
         s  = t[63:0];
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_q.delete();
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_n   = (int'(num_ops) > MAX_OPS) ? MAX_OPS : int'(num_ops);
                  m_cin = cin;
                  m_q.delete();
                  if (m_n == 0) begin
                     ref_sum(m_q, 1'b0, m_sum, m_carry);
                     m_phase = 2;
                  end else begin
                     m_phase = 1;
                  end
               end
            1: if (in_valid) begin
                  m_q.push_back(in_data);
                  if (m_q.size() == m_n) begin
                     ref_sum(m_q, m_cin, m_sum, m_carry);
                     m_phase = 2;
                  end
               end
            default: if (out_ready) begin
                  txn++;
                  $display("txn %0d: ops=%0d cin=%0b sum=%h carry=%0b", txn, m_n, m_cin, m_sum, m_carry);
                  m_phase = 0;
               end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  64'(in_ready),  64'(m_phase == 1));
         check("out_valid", 64'(out_valid), 64'(m_phase == 2));
         check("busy",      64'(busy),      64'(m_phase != 0));
         check("out_sum",   out_sum,        (m_phase == 2) ? m_sum : 64'd0);
         check("out_carry", 64'(out_carry), 64'((m_phase == 2) ? m_carry : 1'b0));
      end
   end

   // ---------------- directed helpers (called at a falling edge) --------
   task automatic do_start(input int n, input logic c);
      start   = 1'b1;
      num_ops = CNT_W'(n);
      cin     = c;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic beat(input logic [63:0] d, input int gap);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic finish_result(input string name, input logic [63:0] es, input logic ec);
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_sum"},   out_sum,        es);
      check({name, "_carry"}, 64'(out_carry), 64'(ec));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_idle"},  64'(busy),      64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_ops = '0; cin = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready),  64'd0);
      check("rst_busy",  64'(busy),      64'd0);
      check("rst_sum",   out_sum,        64'd0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // 1: three back-to-back beats with carry-in
      do_start(3, 1'b1);
      check("t1_ready", 64'(in_ready), 64'd1);
      beat(64'd5, 0); beat(64'd7, 0); beat(64'd9, 0);
      finish_result("t1", 64'd22, 1'b0);

      // 2: wrap-around sets the sticky carry
      do_start(2, 1'b0);
      beat(64'hFFFF_FFFF_FFFF_FFFF, 0); beat(64'd2, 0);
      finish_result("t2a", 64'd1, 1'b1);
      do_start(1, 1'b1);
      beat(64'hFFFF_FFFF_FFFF_FFFF, 0);
      finish_result("t2b", 64'd0, 1'b1);

      // 3: result held under back-pressure, start pulses ignored
      do_start(2, 1'b0);
      beat(64'd100, 0); beat(64'd200, 0);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1; num_ops = CNT_W'(3);
         @(negedge clk);
         check("t3_hold_sum",   out_sum,        64'd300);
         check("t3_hold_ready", 64'(in_ready),  64'd0);
      end
      start = 1'b0;
      finish_result("t3", 64'd300, 1'b0);

      // 4: bubbles between beats
      do_start(4, 1'b0);
      beat(64'd1, 2); beat(64'd2, 2); beat(64'd3, 2);
      check("t4_not_done", 64'(out_valid), 64'd0);
      beat(64'd4, 0);
      finish_result("t4", 64'd10, 1'b0);

      // 5: reset mid-run abandons it
      do_start(4, 1'b0);
      beat(64'd11, 0); beat(64'd22, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rst_busy",  64'(busy),      64'd0);
      check("t5_rst_ready", 64'(in_ready),  64'd0);
      check("t5_rst_valid", 64'(out_valid), 64'd0);
      do_start(2, 1'b0);
      beat(64'd10, 0); beat(64'd20, 0);
      finish_result("t5", 64'd30, 1'b0);

      // 6: zero operands, and a count clamped to MAX_OPS
      do_start(0, 1'b1);
      finish_result("t6a", 64'd0, 1'b0);
      do_start(20, 1'b0);
      for (int i = 0; i < 16; i++) beat(64'd1, 0);
      check("t6_done16", 64'(out_valid), 64'd1);
      in_valid = 1'b1; in_data = 64'd1;
      @(negedge clk);
      in_valid = 1'b0;
      finish_result("t6b", 64'd16, 1'b0);

      // randomized traffic
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst       = ($urandom_range(0, 199) == 0);
         start     = ($urandom_range(0, 3) == 0);
         num_ops   = CNT_W'($urandom_range(0, 20));
         cin       = 1'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0:       in_data = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            1:       in_data = {$urandom, $urandom};
            2:       in_data = 64'($urandom_range(0, 15));
            default: in_data = {1'b1, 31'($urandom), $urandom};
         endcase
         @(negedge clk);
      end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cla_accum.md
Name: cla_accum

Overview:
- Sequential operand-streaming stage that sits directly upstream of, and wraps, the existing 64-bit carry-lookahead adder (CLA_64bit).
- Accepts a programmed count of 64-bit operands over a valid/ready stream and accumulates them through the CLA.
- Presents the final sum and a sticky unsigned-carry flag on a valid/ready result port.
- Used wherever multi-operand sums are needed without a wide adder tree.

Parameters:
- WIDTH, 64, datapath width; fixed by the CLA instance.
- MAX_OPS, 16, maximum operands per accumulation.
- CNT_W, 5, width of num_ops and the internal beat counter.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an accumulation; sampled in IDLE only.
- num_ops  in  CNT_W  operand count, latched on start.
- cin  in  1  carry-in, latched on start, applied to the first add only.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept an operand.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  accumulated sum, modulo 2^64.
- out_carry  out  1  sticky: any add in this run produced an unsigned carry-out.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; acc, count, out_sum, out_carry, in_ready, out_valid and busy are all 0. Reset has priority over every other input in that cycle.
- Reset mid-operation: the run is abandoned. The next cycle is IDLE with all outputs 0, and no result is emitted.

FSM states: IDLE, ACCUM, DONE.

IDLE:
- in_ready=0, out_valid=0.
- On start, latch the following and clear acc, count and the carry flag:
  - num_ops, clamped to MAX_OPS if larger.
  - cin.
- Next state:
  - num_ops==0: go to DONE with out_sum=0 and out_carry=0; cin is ignored.
  - Otherwise: go to ACCUM.

ACCUM:
- in_ready=1.
- A beat is accepted when in_valid and in_ready are both high in the same cycle. On each accepted beat:
  - acc <= CLA(acc, in_data, cin_eff), where cin_eff is the latched cin if count==0, else 0.
  - Carry-out is derived as (sum < acc) or (cin_eff and sum == acc). It is OR'd into the sticky flag.
  - count increments.
- Cycles with in_valid low do not advance count or acc.
- When the accepted beat makes count equal the latched num_ops, go to DONE in the next cycle.

DONE:
- out_valid=1; out_sum=acc; out_carry=flag; in_ready=0.
- Outputs hold stable until out_ready is high, then go to IDLE in the following cycle.

Handshake and timing rules:
- start is ignored in ACCUM and DONE.
- start is not accepted in the same cycle the FSM leaves DONE; it can be accepted from the first IDLE cycle.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Throughput: one operand per cycle.
- Wrap-around: the sum wraps modulo 2^64, and only out_carry records overflow.
- The CLA is combinational between the registered acc and in_data. Its result is registered only on an accepted beat.

Decomposition:
- Shared package cla_pkg:
  - WIDTH=64, MAX_OPS, CNT_W.
  - State typedef {IDLE, ACCUM, DONE}.
- Sub-module: one instance of the existing CLA_64bit, (a=acc, b=in_data, cin=cin_eff, sum).
- Carry detection and the FSM stay in cla_accum.

Test Plan:
1. start, num_ops=3, cin=1; beats 5, 7, 9 back-to-back -> out_sum=22, out_carry=0; out_valid exactly 1 cycle after the third beat.
2. num_ops=2, cin=0; beats 0xFFFF_FFFF_FFFF_FFFF, 2 -> out_sum=1, out_carry=1. Also num_ops=1, cin=1, beat 0xFFFF_FFFF_FFFF_FFFF -> out_sum=0, out_carry=1.
3. Hold out_ready=0 for 5 cycles in DONE, pulsing start -> out_valid, out_sum and out_carry stable; in_ready=0; start ignored. out_ready=1 -> IDLE next cycle.
4. num_ops=4; in_valid with 2-cycle bubbles, beats 1, 2, 3, 4 -> count advances only on handshakes; out_sum=10.
5. rst=1 after 2 of 4 beats -> next cycle IDLE with all outputs 0. A new run, num_ops=2, beats 10, 20 -> out_sum=30, out_carry=0.
6. Boundary counts:
   - num_ops=0 -> DONE next cycle, out_sum=0, out_carry=0.
   - num_ops=20 -> clamped to 16; 16 beats of value 1 -> out_sum=16, and a 17th in_valid beat is not accepted.
